// File: rtl/ps2_mouse_tracker.sv
// ps2_mouse_tracker: assembles 3-byte PS/2 mouse packets from the receiver byte
// stream and accumulates a clamped cursor position plus button state.
// Optional feature macro: PS2_MOUSE_TIMEOUT_EN enables an inter-byte timeout that
// abandons a partial packet after TIMEOUT idle clocks.
module ps2_mouse_tracker #(
  parameter int X_W     = 9,
  parameter int Y_W     = 9,
  parameter int X_MAX   = 319,
  parameter int Y_MAX   = 239,
  parameter int X_INIT  = 160,
  parameter int Y_INIT  = 120,
  parameter int SHIFT   = 0,
  parameter int TIMEOUT = 1000000
) (
  input  logic           clock,
  input  logic           resetn,
  input  logic [7:0]     rx_data,
  input  logic           rx_valid,
  input  logic           recenter,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [2:0]     buttons,
  output logic           left_click,
  output logic           pkt_valid,
  output logic           resync
);

  // Arithmetic width: two guard bits above the wider axis so sums never wrap.
  localparam int W = ((X_W > Y_W) ? X_W : Y_W) + 2;
  localparam logic signed [W-1:0] X_MAX_S = W'(X_MAX);
  localparam logic signed [W-1:0] Y_MAX_S = W'(Y_MAX);
  localparam logic signed [W-1:0] ZERO_S  = W'(0);

  typedef enum logic [1:0] {
    WAIT_B0 = 2'd0,
    WAIT_B1 = 2'd1,
    WAIT_B2 = 2'd2,
    UPDATE  = 2'd3
  } state_t;

  state_t state_r, state_s;

  // Packet fields captured from the three bytes (b0 sync bit 3 is not kept).
  logic [2:0] btn_r;
  logic       dx_hi_r, dy_hi_r, xov_r, yov_r;
  logic [7:0] b1_r, b2_r;

  logic accept_b0_s, accept_b1_s, accept_b2_s, resync_s, timeout_s;

  logic signed [8:0]   dx_raw_s, dy_raw_s, dx_sh_s, dy_sh_s;
  logic signed [W-1:0] dx_w_s, dy_w_s, x_w_s, y_w_s, sum_x_s, sum_y_s;
  logic [X_W-1:0]      x_upd_s;
  logic [Y_W-1:0]      y_upd_s;

`ifdef PS2_MOUSE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_r;

  // Idle counter: runs only while a packet is partially received, cleared by any byte.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_r <= CW'(0);
    end else if (((state_r == WAIT_B1) || (state_r == WAIT_B2)) && !rx_valid) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= CW'(0);
    end
  end

  assign timeout_s = ((state_r == WAIT_B1) || (state_r == WAIT_B2)) &&
                     (cnt_r == CW'(TIMEOUT));
`else
  assign timeout_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r <= WAIT_B0;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and byte-acceptance decode; UPDATE handles a new byte like WAIT_B0.
  always_comb begin
    state_s     = state_r;
    accept_b0_s = 1'b0;
    accept_b1_s = 1'b0;
    accept_b2_s = 1'b0;
    resync_s    = 1'b0;
    case (state_r)
      WAIT_B0, UPDATE: begin
        if (rx_valid) begin
          if (rx_data[3]) begin
            accept_b0_s = 1'b1;
            state_s     = WAIT_B1;
          end else begin
            resync_s = 1'b1;
            state_s  = WAIT_B0;
          end
        end else begin
          state_s = WAIT_B0;
        end
      end
      WAIT_B1: begin
        if (rx_valid) begin
          accept_b1_s = 1'b1;
          state_s     = WAIT_B2;
        end else if (timeout_s) begin
          resync_s = 1'b1;
          state_s  = WAIT_B0;
        end else begin
          state_s = WAIT_B1;
        end
      end
      WAIT_B2: begin
        if (rx_valid) begin
          accept_b2_s = 1'b1;
          state_s     = UPDATE;
        end else if (timeout_s) begin
          resync_s = 1'b1;
          state_s  = WAIT_B0;
        end else begin
          state_s = WAIT_B2;
        end
      end
      default: begin
        state_s = WAIT_B0;
      end
    endcase
  end

  // Packet byte capture.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      btn_r   <= 3'd0;
      dx_hi_r <= 1'b0;
      dy_hi_r <= 1'b0;
      xov_r   <= 1'b0;
      yov_r   <= 1'b0;
      b1_r    <= 8'd0;
      b2_r    <= 8'd0;
    end else begin
      if (accept_b0_s) begin
        btn_r   <= rx_data[2:0];
        dx_hi_r <= rx_data[4];
        dy_hi_r <= rx_data[5];
        xov_r   <= rx_data[6];
        yov_r   <= rx_data[7];
      end
      if (accept_b1_s) begin
        b1_r <= rx_data;
      end
      if (accept_b2_s) begin
        b2_r <= rx_data;
      end
    end
  end

  // Delta scaling and clamped position update; y is inverted since PS/2 +dy is up.
  always_comb begin
    dx_raw_s = $signed({dx_hi_r, b1_r});
    dy_raw_s = $signed({dy_hi_r, b2_r});
    dx_sh_s  = dx_raw_s >>> SHIFT;
    dy_sh_s  = dy_raw_s >>> SHIFT;
    if (xov_r) begin
      dx_w_s = ZERO_S;
    end else begin
      dx_w_s = W'(dx_sh_s);
    end
    if (yov_r) begin
      dy_w_s = ZERO_S;
    end else begin
      dy_w_s = W'(dy_sh_s);
    end
    x_w_s   = $signed({{(W - X_W){1'b0}}, x});
    y_w_s   = $signed({{(W - Y_W){1'b0}}, y});
    sum_x_s = x_w_s + dx_w_s;
    sum_y_s = y_w_s - dy_w_s;
    if (sum_x_s < ZERO_S) begin
      x_upd_s = X_W'(0);
    end else if (sum_x_s > X_MAX_S) begin
      x_upd_s = X_W'(X_MAX);
    end else begin
      x_upd_s = sum_x_s[X_W-1:0];
    end
    if (sum_y_s < ZERO_S) begin
      y_upd_s = Y_W'(0);
    end else if (sum_y_s > Y_MAX_S) begin
      y_upd_s = Y_W'(Y_MAX);
    end else begin
      y_upd_s = sum_y_s[Y_W-1:0];
    end
  end

  // Registered outputs; recenter overrides the position but not the packet strobes.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      x          <= X_W'(X_INIT);
      y          <= Y_W'(Y_INIT);
      buttons    <= 3'd0;
      left_click <= 1'b0;
      pkt_valid  <= 1'b0;
      resync     <= 1'b0;
    end else begin
      pkt_valid  <= (state_r == UPDATE);
      left_click <= (state_r == UPDATE) && btn_r[0] && !buttons[0];
      resync     <= resync_s;
      if (state_r == UPDATE) begin
        buttons <= btn_r;
      end
      if (recenter) begin
        x <= X_W'(X_INIT);
        y <= Y_W'(Y_INIT);
      end else if (state_r == UPDATE) begin
        x <= x_upd_s;
        y <= y_upd_s;
      end
    end
  end

endmodule
